// File: rtl/spmv_row_mac.sv
// spmv_row_mac -- row multiply-accumulate stage of the SpMV kernel.
//
// Joins the gathered Xi stream with the matching nonzero value stream. It
// accumulates the products of each row and emits one Y element per row. The
// per-row nonzero count comes from the Len stream.
//
// Ports
//   clk, rstn              clock, async active-low reset
//   Ctrl_sig[1:0]          element mode (0 int16, 1 int32, 2/3 int64), sampled at Start
//   Start, Row_Count[31:0] job launch pulse and row count (ignored while Busy)
//   Len_*                  per-row nonzero count stream (consumed in LEN)
//   Xi_*, Val_*            X / A operand streams, joined (consumed together in MAC)
//   Y_*                    result stream: row dot product and 0-based row index
//   Busy, Done             job in progress / one-cycle completion pulse
module spmv_row_mac (
  input  logic        clk,
  input  logic        rstn,
  input  logic [1:0]  Ctrl_sig,
  input  logic        Start,
  input  logic [31:0] Row_Count,
  input  logic        Len_valid,
  output logic        Len_ready,
  input  logic [31:0] Len_data,
  input  logic        Xi_valid,
  output logic        Xi_ready,
  input  logic [63:0] Xi_data,
  input  logic        Val_valid,
  output logic        Val_ready,
  input  logic [63:0] Val_data,
  output logic        Y_valid,
  input  logic        Y_ready,
  output logic [63:0] Y_data,
  output logic [31:0] Y_row,
  output logic        Busy,
  output logic        Done
);

  typedef enum logic [2:0] {S_IDLE, S_LEN, S_MAC, S_DRAIN, S_OUT} state_t;

  state_t      state_q, state_d;
  logic [1:0]  mode_q, mode_d;
  logic [31:0] rows_q, rows_d;
  logic [31:0] row_q, row_d;
  logic [31:0] rem_q, rem_d;
  logic [63:0] acc_q, acc_d;
  logic [63:0] prod_q, prod_d;
  logic        prod_v_q, prod_v_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;

  logic        in_mac, fire;
  logic [63:0] x_m, a_m, prod_full;

  // Sign-extend both operands to 64 bits so that a single 64x64 multiplier
  // covers every mode. The narrow products fit in 64 bits, so keeping the
  // low half gives the exact sign-extended result. Mode 3 falls into default.
  always_comb begin
    case (mode_q)
      2'd0: begin
        x_m = {{48{Xi_data[15]}}, Xi_data[15:0]};
        a_m = {{48{Val_data[15]}}, Val_data[15:0]};
      end
      2'd1: begin
        x_m = {{32{Xi_data[31]}}, Xi_data[31:0]};
        a_m = {{32{Val_data[31]}}, Val_data[31:0]};
      end
      default: begin
        x_m = Xi_data;
        a_m = Val_data;
      end
    endcase
  end

  assign prod_full = x_m * a_m;

  // Join: each side is ready only when the other side has data, so the two
  // streams always advance in lockstep.
  assign in_mac    = (state_q == S_MAC);
  assign fire      = in_mac & Xi_valid & Val_valid;
  assign Xi_ready  = in_mac & Val_valid;
  assign Val_ready = in_mac & Xi_valid;
  assign Len_ready = (state_q == S_LEN);
  assign Y_valid   = (state_q == S_OUT);
  assign Y_data    = acc_q;
  assign Y_row     = row_q;
  assign Busy      = busy_q;
  assign Done      = done_q;

  always_comb begin
    state_d  = state_q;
    mode_d   = mode_q;
    rows_d   = rows_q;
    row_d    = row_q;
    rem_d    = rem_q;
    acc_d    = acc_q;
    prod_d   = prod_q;
    prod_v_d = 1'b0;
    busy_d   = busy_q;
    done_d   = 1'b0;

    // The product register drains into the accumulator one cycle after each
    // fire. DRAIN exists only to absorb the final one.
    if (prod_v_q) acc_d = acc_q + prod_q;

    case (state_q)
      S_IDLE: begin
        // A Start pulse that coincides with Done belongs to the finished job
        // and is dropped.
        if (Start && !done_q) begin
          mode_d = Ctrl_sig;
          rows_d = Row_Count;
          row_d  = '0;
          if (Row_Count == 32'd0) begin
            done_d = 1'b1;
          end else begin
            busy_d  = 1'b1;
            state_d = S_LEN;
          end
        end
      end
      S_LEN: begin
        if (Len_valid) begin
          acc_d   = '0;
          rem_d   = Len_data;
          state_d = (Len_data == 32'd0) ? S_OUT : S_MAC;
        end
      end
      S_MAC: begin
        if (fire) begin
          prod_d   = prod_full;
          prod_v_d = 1'b1;
          rem_d    = rem_q - 32'd1;
          if (rem_q == 32'd1) state_d = S_DRAIN;
        end
      end
      S_DRAIN: state_d = S_OUT;
      S_OUT: begin
        if (Y_ready) begin
          row_d = row_q + 32'd1;
          if (row_q + 32'd1 == rows_q) begin
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = S_IDLE;
          end else begin
            state_d = S_LEN;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= S_IDLE;
      mode_q   <= '0;
      rows_q   <= '0;
      row_q    <= '0;
      rem_q    <= '0;
      acc_q    <= '0;
      prod_q   <= '0;
      prod_v_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      mode_q   <= mode_d;
      rows_q   <= rows_d;
      row_q    <= row_d;
      rem_q    <= rem_d;
      acc_q    <= acc_d;
      prod_q   <= prod_d;
      prod_v_q <= prod_v_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

endmodule

// File: doc/spmv_row_mac.md
# spmv_row_mac

Row multiply-accumulate stage of the SpMV kernel, sitting directly downstream of the Xi reader. It joins the gathered Xi stream with the matching nonzero value stream. It accumulates products over each row using a per-row nonzero count stream and emits one Y element per row. Integer arithmetic only; element width is selected by the same Ctrl_sig encoding the Xi reader uses.

## Interface

Parameters:
- none

Ports:
- clk  in  1  single clock for all logic
- rstn  in  1  reset; asynchronous, active-low
- Ctrl_sig  in  2  element mode: 0 = int16, 1 = int32, 2 = int64; 3 is treated as 2; sampled at Start
- Start  in  1  one-cycle pulse that begins a job; ignored while Busy
- Row_Count  in  32  number of rows in the job; sampled at Start
- Len_valid / Len_ready  in / out  1 / 1  row nonzero-count stream handshake
- Len_data  in  32  nonzero count of the current row
- Xi_valid / Xi_ready  in / out  1 / 1  gathered-X stream handshake
- Xi_data  in  64  X element, right-aligned to the mode width
- Val_valid / Val_ready  in / out  1 / 1  matrix-value stream handshake
- Val_data  in  64  A element, right-aligned to the mode width
- Y_valid / Y_ready  out / in  1 / 1  result stream handshake
- Y_data  out  64  row dot product
- Y_row  out  32  index of the row in Y_data, 0-based
- Busy  out  1  high from the cycle after an accepted Start until Done
- Done  out  1  one-cycle pulse when the job completes

## Operation

- States: IDLE, LEN, MAC, DRAIN, OUT.
- IDLE:
  - On Start: latch mode and Row_Count, clear row index, set Busy.
  - Row_Count = 0: pulse Done next cycle and return to IDLE; no Y is produced.
  - Otherwise go to LEN.
- LEN:
  - Len_ready = 1. On Len handshake: clear acc to 0 and load remaining = Len_data.
  - Len_data = 0: go to OUT, so Y = 0.
  - Otherwise go to MAC.
- MAC:
  - Join handshake: Xi_ready = Val_valid; Val_ready = Xi_valid (both gated by state==MAC).
  - fire = Xi_valid & Val_valid, so both streams advance together.
  - Each fire: register the product into prod_q, set prod_v, decrement remaining.
  - The fire with remaining = 1 moves to DRAIN.
- Operand/product rules:
  - Mode 0: signed Xi[15:0] × Val[15:0]; 32-bit product sign-extended to 64.
  - Mode 1: signed [31:0] × [31:0]; full 64-bit product.
  - Mode 2: low 64 bits of the signed 64×64 product.
  - Upper input bits beyond the mode width are ignored.
- Accumulate: each cycle prod_v = 1, acc <= acc + prod_q, modulo 2^64 (wraps, no saturation, no flag).
- DRAIN: wait for the last product to accumulate, then go to OUT.
- OUT:
  - Y_valid = 1; Y_data = acc; Y_row = current row index.
  - Y_data and Y_row are held stable until Y_ready.
  - On Y handshake, increment the row index.
  - Last row: pulse Done, drop Busy, go to IDLE. Otherwise go to LEN.
- No stream is accepted outside its own state; Xi/Val are never consumed in LEN, DRAIN or OUT.

## Timing

- Reset values (async on rstn low): state IDLE; every ready = 0; Y_valid = 0, Y_data = 0, Y_row = 0; Busy = 0, Done = 0; acc, prod_q, prod_v and counters = 0.
- Reset mid-job aborts immediately. In-flight data is discarded and upstream must be reset too.
- Start in cycle t: Busy = 1 and Len_ready = 1 at t+1.
- Throughput: one Xi/Val pair per cycle in MAC.
- Per-row overhead: 1 LEN cycle, 1 DRAIN cycle, and at least 1 OUT cycle.
- Latency: last pair fires in cycle T, so Y_valid = 1 in cycle T+2.
- Zero-length row: Len handshake in cycle t gives Y_valid = 1 at t+1.
- Done is asserted in the cycle after the final Y handshake, for exactly one cycle, with Busy = 0 in the same cycle.
- Start coincident with Done, or asserted while Busy, is ignored.
- Y_ready held low stalls indefinitely with no input consumption and no loss.

## Test plan

- Mode 0, Row_Count = 1, Len = 2, pairs (X=3, A=0xFFFE) and (X=5, A=4) -> one Y: Y_data = 14, Y_row = 0; Y_valid exactly 2 cycles after the second fire; Done pulses once.
- Mode 1, one row, Len = 1, X = 0x0001_0000, A = 0x0001_0000 -> Y_data = 0x0000_0001_0000_0000. Mode 2, X = 0x8000_0000_0000_0000, A = 2 -> Y_data = 0 (wrap).
- Row_Count = 3, Len = {0, 1, 2}, all X = 1, A = {7; 2, 3} -> Y = 0, 7, 5 with Y_row = 0, 1, 2. The zero row's Y_valid comes 1 cycle after its Len handshake.
- Randomised Xi_valid/Val_valid gaps and Y_ready held low 5 cycles in OUT -> results match the reference sum; Y_data stable during stall; no ready asserted outside MAC; pair count consumed equals the sum of Len.
- Row_Count = 0 -> Done at t+1, no Y; Start while Busy -> ignored, job result unchanged.
- rstn low mid-MAC -> all outputs at reset values asynchronously; a new job after reset produces correct results from row 0.
